// File: rtl/divider_pkg.sv
// Shared arithmetic-unit definitions: FSM encoding common to the multiplier
// and divider, plus default operand and counter widths.
package divider_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CNT_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/divider_if.sv
// Controller-to-divider bundle: start/clear controls and operands in,
// results and status back out.
interface divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             op_start;
  logic             op_clear;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             op_done;
  logic             div_zero;

  modport master (
    output op_start, op_clear, dividend, divisor,
    input  quotient, remainder, op_done, div_zero
  );

  modport slave (
    input  op_start, op_clear, dividend, divisor,
    output quotient, remainder, op_done, div_zero
  );

endinterface

// File: rtl/divider_ns_logic.sv
// Next-state / next-count logic for the divider FSM; purely combinational.
// Mirrors the multiplier's block with the terminal count at WIDTH-1.
module div_ns_logic
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [CNT_W-1:0] count,
  input  state_t           state,
  output state_t           next_state,
  output logic [CNT_W-1:0] next_count
);

  always_comb begin
    next_state = IDLE;
    next_count = '0;
    case (state)
      IDLE: begin
        if (!op_clear && op_start) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (!op_clear) begin
          next_count = count + 1'b1;
          next_state = (count == CNT_W'(WIDTH - 1)) ? DONE : EXEC;
        end
      end
      DONE: begin
        if (!op_clear) begin
          next_state = DONE;
          next_count = count;
        end
      end
      // 2'b11 and anything else falls back to IDLE with a cleared count
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Holds results in DONE until op_clear; outputs are pure state decodes.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  divider_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;

  // Trial value keeps the bit shifted out of R so the compare never wraps
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic             in_done;

  assign trial = {r_q, q_q[WIDTH-1]};
  assign fits  = (trial >= {1'b0, d_q});
  assign diff  = trial[WIDTH-1:0] - d_q;

  div_ns_logic #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ns (
    .op_start   (bus.op_start),
    .op_clear   (bus.op_clear),
    .count      (count_q),
    .state      (state_q),
    .next_state (state_d),
    .next_count (count_d)
  );

  always_comb begin
    r_d  = r_q;
    q_d  = q_q;
    d_d  = d_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: begin
        if (!bus.op_clear && bus.op_start) begin
          r_d  = '0;
          q_d  = bus.dividend;
          d_d  = bus.divisor;
          dz_d = (bus.divisor == '0);
        end
      end
      EXEC: begin
        if (bus.op_clear) begin
          r_d  = '0;
          q_d  = '0;
          d_d  = '0;
          dz_d = 1'b0;
        end else begin
          r_d = fits ? diff : trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], fits};
        end
      end
      DONE: begin
        if (bus.op_clear) begin
          r_d  = '0;
          q_d  = '0;
          d_d  = '0;
          dz_d = 1'b0;
        end
      end
      default: begin
        r_d  = '0;
        q_d  = '0;
        d_d  = '0;
        dz_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      dz_q    <= dz_d;
    end
  end

  assign in_done       = (state_q == DONE);
  assign bus.op_done   = in_done;
  assign bus.quotient  = in_done ? q_q : '0;
  assign bus.remainder = in_done ? r_q : '0;
  assign bus.div_zero  = in_done & dz_q;

endmodule
